keycard_spi_responder: RTL and testbench

- Card-side SPI slave (mode 0: CPOL=0, CPHA=0) for the key-card authentication protocol; the peer is the terminal's SPI master.
- Decodes command frames AUTH_INIT/AUTH/GET_ID and enforces command ordering.
- Forwards each accepted command to an external AES engine through a request/response handshake.
- Serves the 16-byte result to the master in a separate READ_RSP frame.

---
 rtl/keycard_spi_responder_pkg.sv | 52 +++++
 rtl/keycard_spi_responder_spi_slave_byte.sv | 118 +++++++++++
 rtl/keycard_spi_responder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_keycard_spi_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keycard_spi_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : keycard_pkg
// Brief   : Shared opcodes, status codes and state encodings for the key-card
//           SPI responder.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package keycard_pkg;

    localparam logic [7:0] OP_AUTH_INIT = 8'h10;
    localparam logic [7:0] OP_AUTH      = 8'h11;
    localparam logic [7:0] OP_GET_ID    = 8'h12;
    localparam logic [7:0] OP_READ_RSP  = 8'h20;

    localparam logic [7:0] ST_IDLE = 8'h00;
    localparam logic [7:0] ST_BUSY = 8'hB0;
    localparam logic [7:0] ST_OK   = 8'h01;
    localparam logic [7:0] ST_ERR  = 8'hEE;

    typedef enum logic [1:0] {
        REQ_CHAL = 2'd0,
        REQ_AUTH = 2'd1,
        REQ_ID   = 2'd2
    } req_op_t;

    typedef enum logic {
        AUTH_NONE      = 1'b0,
        AUTH_CHAL_SENT = 1'b1
    } auth_state_t;

    typedef enum logic [2:0] {
        FR_IDLE    = 3'd0,
        FR_OPCODE  = 3'd1,
        FR_PAYLOAD = 3'd2,
        FR_DISCARD = 3'd3,
        FR_READOUT = 3'd4
    } frame_state_t;

    // What a frame asks for when chip select is released.
    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_ERR  = 3'd1,
        CMD_INIT = 3'd2,
        CMD_AUTH = 3'd3,
        CMD_ID   = 3'd4
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/keycard_spi_responder_spi_slave_byte.sv
//------------------------------------------------------------------------------
// Module  : spi_slave_byte
// Brief   : Mode-0 SPI byte engine: input synchronizers, edge detection and
//           the receive/transmit shift registers, all in the system clock.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_slave_byte
    import keycard_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_clk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    input  logic [7:0] tx_byte_i,
    output logic       spi_miso_o,
    output logic       cs_active_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_dv_o,
    output logic [7:0] byte_idx_o,
    output logic       cs_fall_o,
    output logic       cs_rise_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             rx_shift_q;
    logic [7:0]             rx_byte_q;
    logic                   rx_dv_q;
    logic [7:0]             tx_shift_q;
    logic [7:0]             byte_idx_q;

    logic w_sck;
    logic w_cs_n;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_sck  = sck_sync_q[SYNC_STAGES-1];
    assign w_cs_n = cs_sync_q[SYNC_STAGES-1];
    assign w_mosi = mosi_sync_q[SYNC_STAGES-1];

    // SCK edges only count while the frame is open.
    assign w_sck_rise = w_sck & ~sck_prev_q & ~w_cs_n;
    assign w_sck_fall = ~w_sck & sck_prev_q & ~w_cs_n;
    assign cs_fall_o  = ~w_cs_n & cs_prev_q;
    assign cs_rise_o  = w_cs_n & ~cs_prev_q;

    assign cs_active_o = ~w_cs_n;
    assign spi_miso_o  = tx_shift_q[7];
    assign rx_byte_o   = rx_byte_q;
    assign rx_dv_o     = rx_dv_q;
    assign byte_idx_o  = byte_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            rx_byte_q   <= 8'd0;
            rx_dv_q     <= 1'b0;
            tx_shift_q  <= 8'd0;
            byte_idx_q  <= 8'd0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_prev_q  <= w_sck;
            cs_prev_q   <= w_cs_n;
            rx_dv_q     <= 1'b0;

            if (cs_fall_o) begin
                bit_cnt_q  <= 3'd0;
                byte_idx_q <= 8'd0;
                tx_shift_q <= tx_byte_i;
            end else if (cs_rise_o) begin
                bit_cnt_q  <= 3'd0;
                tx_shift_q <= 8'd0;
            end else begin
                if (w_sck_rise) begin
                    rx_shift_q <= {rx_shift_q[5:0], w_mosi};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q <= {rx_shift_q, w_mosi};
                        rx_dv_q   <= 1'b1;
                        if (byte_idx_q != 8'hFF) begin
                            byte_idx_q <= byte_idx_q + 8'd1;
                        end
                    end
                end
                // A fall with the bit counter wrapped is the byte boundary.
                if (w_sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_q <= tx_byte_i;
                    end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/keycard_spi_responder.sv
//------------------------------------------------------------------------------
// Module  : keycard_spi_responder
// Brief   : Card-side SPI responder for key-card authentication: frame decode,
//           command ordering, crypto engine handshake and result readout.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module keycard_spi_responder
    import keycard_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_SPI_Clk,
    input  logic                     i_SPI_CS_n,
    input  logic                     i_SPI_MOSI,
    output logic                     o_SPI_MISO,
    output logic                     o_SPI_MISO_En,
    output logic                     o_Req_Valid,
    output logic [1:0]               o_Req_Op,
    output logic [8*BLOCK_BYTES-1:0] o_Req_Data,
    input  logic                     i_Req_Ready,
    input  logic                     i_Rsp_Valid,
    input  logic                     i_Rsp_Ok,
    input  logic [8*BLOCK_BYTES-1:0] i_Rsp_Data,
    output logic                     o_Authed,
    output logic                     o_Busy
);

    localparam int DATA_W = 8 * BLOCK_BYTES;
    localparam int CNT_W  = $clog2(BLOCK_BYTES + 1);
    localparam int SEL_W  = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(BLOCK_BYTES);
    localparam logic [7:0]       c_LAST_IDX = 8'(BLOCK_BYTES + 1);

    frame_state_t       state_q,     state_d;
    logic [7:0]         opcode_q,    opcode_d;
    logic [DATA_W-1:0]  payload_q,   payload_d;
    logic [CNT_W-1:0]   pay_cnt_q,   pay_cnt_d;
    logic [7:0]         status_q,    status_d;
    logic [DATA_W-1:0]  buf_q,       buf_d;
    auth_state_t        auth_q,      auth_d;
    logic               authed_q,    authed_d;
    logic               busy_q,      busy_d;
    logic               req_valid_q, req_valid_d;
    req_op_t            req_op_q,    req_op_d;
    logic [DATA_W-1:0]  req_data_q,  req_data_d;

    logic [7:0]       w_rx_byte;
    logic             w_rx_dv;
    logic [7:0]       w_byte_idx;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic [7:0]       w_tx_byte;
    logic             w_rsp_take;
    logic             w_busy_eff;
    logic [SEL_W-1:0] w_sel;
    cmd_t             w_cmd;

    spi_slave_byte #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk_i       (i_Clk),
        .rst_i       (i_Rst),
        .spi_clk_i   (i_SPI_Clk),
        .spi_cs_n_i  (i_SPI_CS_n),
        .spi_mosi_i  (i_SPI_MOSI),
        .tx_byte_i   (w_tx_byte),
        .spi_miso_o  (o_SPI_MISO),
        .cs_active_o (o_SPI_MISO_En),
        .rx_byte_o   (w_rx_byte),
        .rx_dv_o     (w_rx_dv),
        .byte_idx_o  (w_byte_idx),
        .cs_fall_o   (w_cs_fall),
        .cs_rise_o   (w_cs_rise)
    );

    // A response only counts once the engine has taken the request.
    assign w_rsp_take = i_Rsp_Valid & busy_q & ~req_valid_q;
    assign w_busy_eff = busy_q & ~w_rsp_take;
    assign w_sel      = SEL_W'(c_LAST_IDX - w_byte_idx);

    // Readout byte map: 0 opcode slot, 1 status, 2..BLOCK_BYTES+1 buffer.
    always_comb begin
        w_tx_byte = 8'h00;
        if (state_q == FR_READOUT) begin
            if (w_byte_idx == 8'd1) begin
                w_tx_byte = status_q;
            end else if ((w_byte_idx >= 8'd2) && (w_byte_idx <= c_LAST_IDX) &&
                         (status_q == ST_OK)) begin
                w_tx_byte = buf_q[{w_sel, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        payload_d   = payload_q;
        pay_cnt_d   = pay_cnt_q;
        status_d    = status_q;
        buf_d       = buf_q;
        auth_d      = auth_q;
        authed_d    = authed_q;
        busy_d      = busy_q;
        req_valid_d = req_valid_q;
        req_op_d    = req_op_q;
        req_data_d  = req_data_q;
        w_cmd       = CMD_NONE;

        if (req_valid_q && i_Req_Ready) begin
            req_valid_d = 1'b0;
        end

        if (w_rsp_take) begin
            busy_d = 1'b0;
            if (i_Rsp_Ok) begin
                buf_d    = i_Rsp_Data;
                status_d = ST_OK;
            end else begin
                buf_d    = '0;
                status_d = ST_ERR;
            end
            if (req_op_q == REQ_CHAL && i_Rsp_Ok) begin
                auth_d = AUTH_CHAL_SENT;
            end else if (req_op_q == REQ_AUTH) begin
                if (i_Rsp_Ok) begin
                    authed_d = 1'b1;
                end else begin
                    auth_d   = AUTH_NONE;
                    authed_d = 1'b0;
                end
            end
        end

        case (state_q)
            FR_IDLE: begin
                if (w_cs_fall) begin
                    state_d   = FR_OPCODE;
                    pay_cnt_d = '0;
                end
            end
            FR_OPCODE: begin
                if (w_rx_dv) begin
                    opcode_d = w_rx_byte;
                    if (w_rx_byte == OP_AUTH) begin
                        state_d = FR_PAYLOAD;
                    end else if (w_rx_byte == OP_READ_RSP) begin
                        state_d = FR_READOUT;
                    end else begin
                        state_d = FR_DISCARD;
                    end
                end
            end
            FR_PAYLOAD: begin
                if (w_rx_dv && (pay_cnt_q != c_FULL_CNT)) begin
                    payload_d = {payload_q[DATA_W-9:0], w_rx_byte};
                    pay_cnt_d = pay_cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (w_cs_rise) begin
            state_d = FR_IDLE;
            if (state_q == FR_DISCARD) begin
                if (opcode_q == OP_AUTH_INIT) begin
                    w_cmd = CMD_INIT;
                end else if (opcode_q == OP_GET_ID) begin
                    w_cmd = CMD_ID;
                end else begin
                    w_cmd = CMD_ERR;
                end
            end else if (state_q == FR_PAYLOAD) begin
                if (pay_cnt_q == c_FULL_CNT) begin
                    w_cmd = CMD_AUTH;
                end else begin
                    w_cmd = CMD_ERR;
                end
            end
        end

        // Commit sees the auth state already updated by a same-cycle response.
        if (!w_busy_eff) begin
            case (w_cmd)
                CMD_INIT: begin
                    authed_d    = 1'b0;
                    auth_d      = AUTH_NONE;
                    req_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    req_op_d    = REQ_CHAL;
                    req_data_d  = '0;
                    status_d    = ST_BUSY;
                end
                CMD_AUTH: begin
                    if (auth_d == AUTH_CHAL_SENT) begin
                        req_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        req_op_d    = REQ_AUTH;
                        req_data_d  = payload_q;
                        status_d    = ST_BUSY;
                    end else begin
                        status_d = ST_ERR;
                    end
                end
                CMD_ID: begin
                    if (authed_d) begin
                        req_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        req_op_d    = REQ_ID;
                        req_data_d  = '0;
                        status_d    = ST_BUSY;
                    end else begin
                        status_d = ST_ERR;
                    end
                end
                CMD_ERR: begin
                    status_d = ST_ERR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= FR_IDLE;
            opcode_q    <= 8'h00;
            payload_q   <= '0;
            pay_cnt_q   <= '0;
            status_q    <= ST_IDLE;
            buf_q       <= '0;
            auth_q      <= AUTH_NONE;
            authed_q    <= 1'b0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_op_q    <= REQ_CHAL;
            req_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            payload_q   <= payload_d;
            pay_cnt_q   <= pay_cnt_d;
            status_q    <= status_d;
            buf_q       <= buf_d;
            auth_q      <= auth_d;
            authed_q    <= authed_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            req_op_q    <= req_op_d;
            req_data_q  <= req_data_d;
        end
    end

    assign o_Req_Valid = req_valid_q;
    assign o_Req_Op    = req_op_q;
    assign o_Req_Data  = req_data_q;
    assign o_Authed    = authed_q;
    assign o_Busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_keycard_spi_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_keycard_spi_responder
// Brief   : Directed self-checking bench for the key-card SPI responder.
// Rev     : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_keycard_spi_responder;

    localparam logic [127:0] c_CHAL_DATA = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] c_ID_DATA   = 128'hbbe8278a67f960605adafd6f63cf7ba7;
    localparam logic [127:0] c_A5_DATA   = {16{8'hA5}};
    localparam logic [127:0] c_SEQ_DATA  = 128'h0102030405060708090A0B0C0D0E0F10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic         miso_en;
    logic         req_valid;
    logic [1:0]   req_op;
    logic [127:0] req_data;
    logic         req_ready = 1'b0;
    logic         rsp_valid = 1'b0;
    logic         rsp_ok = 1'b0;
    logic [127:0] rsp_data = '0;
    logic         authed;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   r_b0, r_st, r_b18;
    logic [127:0] r_data;

    always #5 clk = ~clk;

    keycard_spi_responder #(
        .SYNC_STAGES (2),
        .BLOCK_BYTES (16)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_SPI_Clk     (sck),
        .i_SPI_CS_n    (cs_n),
        .i_SPI_MOSI    (mosi),
        .o_SPI_MISO    (miso),
        .o_SPI_MISO_En (miso_en),
        .o_Req_Valid   (req_valid),
        .o_Req_Op      (req_op),
        .o_Req_Data    (req_data),
        .i_Req_Ready   (req_ready),
        .i_Rsp_Valid   (rsp_valid),
        .i_Rsp_Ok      (rsp_ok),
        .i_Rsp_Data    (rsp_data),
        .o_Authed      (authed),
        .o_Busy        (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        clocks(8);
    endtask

    task automatic cs_high();
        clocks(8);
        cs_n = 1'b1;
        clocks(8);
    endtask

    // Master side: MOSI set while SCK low, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            clocks(8);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            clocks(8);
            sck = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] op);
        logic [7:0] d;
        cs_low();
        spi_bits(op, 8, d);
        cs_high();
    endtask

    task automatic send_auth(input logic [127:0] pl, input int nbytes);
        logic [7:0] d;
        cs_low();
        spi_bits(8'h11, 8, d);
        for (int i = 0; i < nbytes; i++) begin
            if (i < 16) spi_bits(pl[127-8*i -: 8], 8, d);
            else        spi_bits(8'h3C, 8, d);
        end
        cs_high();
    endtask

    task automatic read_rsp(output logic [7:0] b0, output logic [7:0] st,
                            output logic [127:0] data, output logic [7:0] b18);
        logic [7:0] d;
        cs_low();
        spi_bits(8'h20, 8, b0);
        spi_bits(8'h00, 8, st);
        data = '0;
        for (int i = 0; i < 16; i++) begin
            spi_bits(8'h00, 8, d);
            data = {data[119:0], d};
        end
        spi_bits(8'h00, 8, b18);
        cs_high();
    endtask

    task automatic accept();
        req_ready = 1'b1;
        clocks(1);
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic ok, input logic [127:0] d);
        rsp_valid = 1'b1;
        rsp_ok    = ok;
        rsp_data  = d;
        clocks(1);
        rsp_valid = 1'b0;
        rsp_ok    = 1'b0;
        rsp_data  = '0;
        clocks(2);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        clocks(2);
    endtask

    task automatic do_chal();
        send_cmd(8'h10);
        accept();
        respond(1'b1, c_CHAL_DATA);
    endtask

    initial begin
        // Reset state
        clocks(4);
        check("reset_outputs", {121'd0, miso, miso_en, req_valid, req_op, authed, busy}, 128'd0);
        check("reset_req_data", req_data, 128'd0);
        rst = 1'b0;
        clocks(2);

        // READ_RSP straight after reset
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("rst_read_b0", {120'd0, r_b0}, 128'h00);
        check("rst_read_status", {120'd0, r_st}, 128'h00);
        check("rst_read_data", r_data, 128'd0);
        check("rst_read_valid_authed", {126'd0, req_valid, authed}, 128'd0);

        // AUTH_INIT -> CHAL request held while engine stalls
        send_cmd(8'h10);
        check("chal_req", {124'd0, req_valid, req_op, busy}, {124'd0, 1'b1, 2'd0, 1'b1});
        check("chal_req_data", req_data, 128'd0);
        clocks(5);
        check("chal_req_held", {125'd0, req_valid, req_op}, {125'd0, 1'b1, 2'd0});
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("busy_read_status", {120'd0, r_st}, 128'hB0);
        check("busy_read_data", r_data, 128'd0);
        accept();
        check("chal_accepted", {126'd0, req_valid, busy}, {126'd0, 1'b0, 1'b1});
        respond(1'b1, c_CHAL_DATA);
        check("chal_done_busy", {127'd0, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("chal_read_b0", {120'd0, r_b0}, 128'h00);
        check("chal_read_status", {120'd0, r_st}, 128'h01);
        check("chal_read_data", r_data, c_CHAL_DATA);
        check("chal_read_b18", {120'd0, r_b18}, 128'h00);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("chal_reread_data", r_data, c_CHAL_DATA);

        // AUTH with one excess byte
        send_auth(c_A5_DATA, 17);
        check("auth_req", {125'd0, req_valid, req_op}, {125'd0, 1'b1, 2'd1});
        check("auth_req_data", req_data, c_A5_DATA);
        accept();
        respond(1'b1, 128'd0);
        check("auth_ok_authed", {127'd0, authed}, 128'd1);

        // GET_ID once authenticated
        send_cmd(8'h12);
        check("id_req", {125'd0, req_valid, req_op}, {125'd0, 1'b1, 2'd2});
        check("id_req_data", req_data, 128'd0);
        accept();
        respond(1'b1, c_ID_DATA);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("id_read_status", {120'd0, r_st}, 128'h01);
        check("id_read_data", r_data, c_ID_DATA);

        // Out-of-order commands from reset
        pulse_reset();
        send_cmd(8'h12);
        check("unauth_id_noreq", {126'd0, req_valid, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("unauth_id_status", {120'd0, r_st}, 128'hEE);
        pulse_reset();
        send_auth(c_A5_DATA, 16);
        check("nochal_auth_noreq", {126'd0, req_valid, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("nochal_auth_status", {120'd0, r_st}, 128'hEE);

        // Protocol faults
        pulse_reset();
        do_chal();
        cs_low();
        spi_bits(8'h10, 3, r_b0);
        cs_high();
        check("partial_noreq", {126'd0, req_valid, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("partial_status", {120'd0, r_st}, 128'h01);
        send_auth(c_A5_DATA, 9);
        check("short_auth_noreq", {126'd0, req_valid, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("short_auth_status", {120'd0, r_st}, 128'hEE);
        send_auth(c_SEQ_DATA, 16);
        check("seq_auth_req", {125'd0, req_valid, req_op}, {125'd0, 1'b1, 2'd1});
        check("seq_auth_data", req_data, c_SEQ_DATA);
        accept();
        respond(1'b0, c_ID_DATA);
        check("auth_fail_authed", {127'd0, authed}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("auth_fail_status", {120'd0, r_st}, 128'hEE);
        check("auth_fail_data", r_data, 128'd0);
        do_chal();
        send_cmd(8'h7F);
        check("badop_noreq", {126'd0, req_valid, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("badop_status", {120'd0, r_st}, 128'hEE);

        // Reset while a request is outstanding
        send_cmd(8'h10);
        check("pre_rst_busy", {127'd0, busy}, 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {121'd0, miso, miso_en, req_valid, req_op, authed, busy}, 128'd0);
        check("midrst_req_data", req_data, 128'd0);
        rst = 1'b0;
        clocks(2);
        respond(1'b1, c_CHAL_DATA);
        check("late_rsp_busy", {127'd0, busy}, 128'd0);
        read_rsp(r_b0, r_st, r_data, r_b18);
        check("late_rsp_status", {120'd0, r_st}, 128'h00);
        check("late_rsp_data", r_data, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
